// File: rtl/mcu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mcu_pkg
// Brief   : Shared types and constants for the uCOM-43 program ROM controller.
//           MCU_ROM_CHECKSUM_EN adds the BAD state to rom_state_t.
// Revision: 1.0
// ============================================================================
package mcu_pkg;

   localparam int ADDR_W_DEF = 11;
   localparam int DATA_W_DEF = 8;
   localparam int ROM_DEPTH  = 2**ADDR_W_DEF;

   typedef enum logic [2:0] {
      ST_BOOT   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_RUN    = 3'd3
`ifdef MCU_ROM_CHECKSUM_EN
      ,ST_BAD   = 3'd4
`endif
   } rom_state_t;

endpackage
`default_nettype wire

// File: rtl/mcu_rom_bram.sv
`default_nettype none
// ============================================================================
// Module  : mcu_rom_bram
// Brief   : Single-port synchronous RAM, 2**ADDR_W x DATA_W, registered read.
// Revision: 1.0
// ============================================================================
module mcu_rom_bram #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // No reset on contents or output so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mcu_rom_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mcu_rom_ctrl
// Brief   : uCOM-43 program ROM owner: fetch / download / debug arbitration and
//           MCU reset sequencing. MCU_ROM_CHECKSUM_EN adds rom_sum/exp_sum/BAD.
// Revision: 1.0
// ============================================================================
module mcu_rom_ctrl
   import mcu_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int SETTLE_CYC = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   output logic [DATA_W-1:0] cpu_data_o,
   output logic              cpu_ph_o,
   output logic              cpu_reset_o,
   input  logic              dl_active_i,
   input  logic              dl_wr_i,
   input  logic [15:0]       dl_addr_i,
   input  logic [DATA_W-1:0] dl_data_i,
   output logic              dl_ovf_o,
   input  logic              dbg_req_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   output logic              dbg_ack_o,
   output logic [DATA_W-1:0] dbg_data_o,
   output logic              loaded_o,
   output logic [ADDR_W:0]   byte_cnt_o
`ifdef MCU_ROM_CHECKSUM_EN
   ,
   input  logic [DATA_W-1:0] exp_sum_i,
   output logic [DATA_W-1:0] rom_sum_o
`endif
);

   localparam int              c_CNT_W       = $clog2(SETTLE_CYC);
   localparam logic [c_CNT_W-1:0] c_SETTLE_INIT = c_CNT_W'(SETTLE_CYC - 1);
   localparam logic [ADDR_W:0] c_BYTE_MAX    = (ADDR_W+1)'(2**ADDR_W);

   rom_state_t          state_q, state_d;
   logic [c_CNT_W-1:0]  settle_q;
   logic                ph_q, ph_d;
   logic [DATA_W-1:0]   cpu_data_q, dbg_data_q;
   logic                steal_q, dbg_ack_q;
   logic                ovf_q, loaded_q;
   logic [ADDR_W:0]     byte_cnt_q, byte_cnt_d;

   logic                w_dl_win, w_dl_inrange, w_dl_acc, w_dl_drop;
   logic                w_load_entry, w_load_exit;
   logic                w_dbg_slot, w_dbg_gnt;
   logic                w_ram_we;
   logic [ADDR_W-1:0]   w_ram_addr;
   logic [DATA_W-1:0]   w_ram_rdata;
   logic [ADDR_W:0]     w_cnt_base;

   // A write is taken in LOAD (including the cycle dl_active falls) and on
   // the entry cycle, so download always wins the single RAM port.
   assign w_dl_win     = (state_q == ST_LOAD) || dl_active_i;
   assign w_dl_inrange = (dl_addr_i >> ADDR_W) == 16'd0;
   assign w_dl_acc     = dl_wr_i && w_dl_win && w_dl_inrange;
   assign w_dl_drop    = dl_wr_i && w_dl_win && !w_dl_inrange;
   assign w_load_entry = (state_q != ST_LOAD) && dl_active_i;
   assign w_load_exit  = (state_q == ST_LOAD) && !dl_active_i;

`ifdef MCU_ROM_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q;
   logic [DATA_W-1:0] w_sum_base, w_sum_next;
   logic              w_sum_bad;

   assign w_sum_base = w_load_entry ? '0 : sum_q;
   assign w_sum_next = w_dl_acc ? (w_sum_base + dl_data_i) : w_sum_base;
   assign w_sum_bad  = (w_sum_next != exp_sum_i);
   assign rom_sum_o  = sum_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q <= '0;
      end else if (w_load_entry || (state_q == ST_LOAD)) begin
         sum_q <= w_sum_next;
      end
   end
`endif

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_BOOT:   state_d = dl_active_i ? ST_LOAD : ST_SETTLE;
         ST_LOAD: begin
            if (!dl_active_i) begin
`ifdef MCU_ROM_CHECKSUM_EN
               state_d = w_sum_bad ? ST_BAD : ST_SETTLE;
`else
               state_d = ST_SETTLE;
`endif
            end
         end
         ST_SETTLE: begin
            if (dl_active_i) begin
               state_d = ST_LOAD;
            end else if (settle_q == '0) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN:    if (dl_active_i) state_d = ST_LOAD;
`ifdef MCU_ROM_CHECKSUM_EN
         ST_BAD:    if (dl_active_i) state_d = ST_LOAD;
`endif
         default:   state_d = ST_BOOT;
      endcase
   end

   always_comb begin
      cpu_reset_o = (state_q != ST_RUN);
      unique case (state_q)
         ST_LOAD: w_dbg_slot = 1'b0;
         ST_RUN:  w_dbg_slot = ph_q;
         default: w_dbg_slot = 1'b1;
      endcase
   end

   // ---------------------------------------------------------- arbitration
   assign w_dbg_gnt  = dbg_req_i && w_dbg_slot && !dl_active_i && !steal_q && !dbg_ack_q;
   assign w_ram_we   = w_dl_acc;
   assign w_ram_addr = w_dl_acc  ? dl_addr_i[ADDR_W-1:0] :
                       w_dbg_gnt ? dbg_addr_i : cpu_addr_i;

   // Phase only runs while both this and the next cycle are RUN, so it is
   // never high while the core is held in reset.
   assign ph_d = (state_q == ST_RUN) && (state_d == ST_RUN) && !ph_q;

   assign w_cnt_base = w_load_entry ? '0 : byte_cnt_q;
   assign byte_cnt_d = (w_dl_acc && (w_cnt_base != c_BYTE_MAX)) ?
                       w_cnt_base + (ADDR_W+1)'(1) : w_cnt_base;

   mcu_rom_bram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_bram (
      .clk     (clk),
      .we_i    (w_ram_we),
      .addr_i  (w_ram_addr),
      .wdata_i (dl_data_i),
      .rdata_o (w_ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         settle_q   <= c_SETTLE_INIT;
         ph_q       <= 1'b0;
         cpu_data_q <= '0;
         dbg_data_q <= '0;
         steal_q    <= 1'b0;
         dbg_ack_q  <= 1'b0;
         ovf_q      <= 1'b0;
         loaded_q   <= 1'b0;
         byte_cnt_q <= '0;
      end else begin
         if (state_q != ST_SETTLE) begin
            settle_q <= c_SETTLE_INIT;
         end else if (settle_q != '0) begin
            settle_q <= settle_q - c_CNT_W'(1);
         end
         ph_q      <= ph_d;
         steal_q   <= w_dbg_gnt;
         dbg_ack_q <= steal_q;
         // RAM output carries debug data one cycle after a stolen slot.
         if (steal_q) begin
            dbg_data_q <= w_ram_rdata;
         end else begin
            cpu_data_q <= w_ram_rdata;
         end
         if (w_dl_drop) ovf_q <= 1'b1;
         if (w_load_exit) loaded_q <= 1'b1;
         byte_cnt_q <= byte_cnt_d;
      end
   end

   assign cpu_data_o = cpu_data_q;
   assign cpu_ph_o   = ph_q;
   assign dl_ovf_o   = ovf_q;
   assign dbg_ack_o  = dbg_ack_q;
   assign dbg_data_o = dbg_data_q;
   assign loaded_o   = loaded_q;
   assign byte_cnt_o = byte_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mcu_rom_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_mcu_rom_ctrl
// Brief   : Scoreboard bench for mcu_rom_ctrl with a byte-array ROM model.
// Revision: 1.0
// ============================================================================
module tb_mcu_rom_ctrl;

   localparam int ADDR_W     = 11;
   localparam int DATA_W     = 8;
   localparam int SETTLE_CYC = 4;
   localparam int DEPTH      = 1 << ADDR_W;

   logic              clk       = 1'b0;
   logic              reset     = 1'b1;
   logic [ADDR_W-1:0] cpu_addr  = '0;
   logic [DATA_W-1:0] cpu_data;
   logic              cpu_ph;
   logic              cpu_reset;
   logic              dl_active = 1'b0;
   logic              dl_wr     = 1'b0;
   logic [15:0]       dl_addr   = '0;
   logic [DATA_W-1:0] dl_data   = '0;
   logic              dl_ovf;
   logic              dbg_req   = 1'b0;
   logic [ADDR_W-1:0] dbg_addr  = '0;
   logic              dbg_ack;
   logic [DATA_W-1:0] dbg_data;
   logic              loaded;
   logic [ADDR_W:0]   byte_cnt;
`ifdef MCU_ROM_CHECKSUM_EN
   logic [DATA_W-1:0] exp_sum = '0;
   logic [DATA_W-1:0] rom_sum;
`endif

   mcu_rom_ctrl #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .SETTLE_CYC (SETTLE_CYC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_addr_i  (cpu_addr),
      .cpu_data_o  (cpu_data),
      .cpu_ph_o    (cpu_ph),
      .cpu_reset_o (cpu_reset),
      .dl_active_i (dl_active),
      .dl_wr_i     (dl_wr),
      .dl_addr_i   (dl_addr),
      .dl_data_i   (dl_data),
      .dl_ovf_o    (dl_ovf),
      .dbg_req_i   (dbg_req),
      .dbg_addr_i  (dbg_addr),
      .dbg_ack_o   (dbg_ack),
      .dbg_data_o  (dbg_data),
      .loaded_o    (loaded),
      .byte_cnt_o  (byte_cnt)
`ifdef MCU_ROM_CHECKSUM_EN
      ,
      .exp_sum_i   (exp_sum),
      .rom_sum_o   (rom_sum)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  model_mem [DEPTH];
   bit          exp_ovf  = 1'b0;
   logic [7:0]  last_sum = '0;
   wr_t         wq[$];
   logic [7:0]  dbg_q[$];
   logic [7:0]  fetch_q[$];
   logic        fetch_chk = 1'b0;
   logic        hold_chk  = 1'b0;
   logic [7:0]  hold_exp  = '0;
   logic        in_load   = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: consumes scoreboard entries whenever the DUT presents data.
   always @(negedge clk) begin
      if (dbg_ack) begin
         check("dbg_ack_outside_load", in_load, 0);
         check("dbg_ack_expected", dbg_q.size() > 0, 1);
         if (dbg_q.size() > 0) check("dbg_data", dbg_data, dbg_q.pop_front());
      end
      if (fetch_chk) begin
         check("fetch_expected", fetch_q.size() > 0, 1);
         if (fetch_q.size() > 0) check("fetch_data", cpu_data, fetch_q.pop_front());
      end
      if (hold_chk && cpu_ph && !cpu_reset) check("fetch_during_dbg", cpu_data, hold_exp);
   end

   task automatic wait_run(output int n);
      n = 0;
      while (cpu_reset && n < 100) begin
         tick();
         n++;
      end
      check("reach_run", cpu_reset, 0);
   endtask

   task automatic fetch(input logic [ADDR_W-1:0] a);
      cpu_addr = a;
      tick();
      tick();
      fetch_q.push_back(model_mem[a]);
      fetch_chk = 1'b1;
      tick();
      fetch_chk = 1'b0;
   endtask

   task automatic dbg_read(input logic [ADDR_W-1:0] a, input logic [7:0] exp,
                           input int max_lat, output int lat);
      dbg_addr = a;
      dbg_req  = 1'b1;
      dbg_q.push_back(exp);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!dbg_ack && lat < 10000);
      dbg_req = 1'b0;
      check("dbg_ack_seen", dbg_ack, 1);
      if (max_lat > 0) check("dbg_latency_ok", lat <= max_lat, 1);
   endtask

   task automatic run_download();
      int         acc = 0;
      logic [7:0] sum = '0;
      int         exp_cnt;
      dl_active = 1'b1;
      in_load   = 1'b1;
      tick();
      check("cpu_reset_on_dl", cpu_reset, 1);
      for (int i = 0; i < wq.size(); i++) begin
         dl_wr   = 1'b1;
         dl_addr = wq[i].a;
         dl_data = wq[i].d;
         if (i == wq.size() - 1) dl_active = 1'b0;
         if (wq[i].a < 16'(DEPTH)) begin
            model_mem[wq[i].a[ADDR_W-1:0]] = wq[i].d;
            acc++;
            sum += wq[i].d;
         end else begin
            exp_ovf = 1'b1;
         end
         tick();
      end
      dl_wr   = 1'b0;
      in_load = 1'b0;
      exp_cnt = (acc > DEPTH) ? DEPTH : acc;
      check("byte_cnt", byte_cnt, exp_cnt);
      check("loaded", loaded, 1);
      check("dl_ovf", dl_ovf, exp_ovf);
      last_sum = sum;
      wq.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int         n;
      int         lat;
      int         released;
      logic [ADDR_W-1:0] a;
      wr_t        w;

      repeat (3) tick();
      check("rst_cpu_data", cpu_data, 0);
      check("rst_cpu_ph", cpu_ph, 0);
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_dl_ovf", dl_ovf, 0);
      check("rst_dbg_ack", dbg_ack, 0);
      check("rst_dbg_data", dbg_data, 0);
      check("rst_loaded", loaded, 0);
      check("rst_byte_cnt", byte_cnt, 0);

      // Boot with no download: BOOT for one cycle, then SETTLE_CYC cycles.
      reset = 1'b0;
      wait_run(n);
      check("boot_cycles", n, 1 + SETTLE_CYC);
      check("run_entry_ph", cpu_ph, 0);
      tick();
      check("ph_toggles", cpu_ph, 1);

      // Full image of addr[7:0] plus three rewrites (count saturates);
      // a debug read raised with dl_active must wait for LOAD exit.
      for (int i = 0; i < DEPTH; i++) begin
         w.a = 16'(i);
         w.d = 8'(i);
         wq.push_back(w);
      end
      for (int i = 0; i < 3; i++) begin
         w.a = 16'(i);
         w.d = 8'(i);
         wq.push_back(w);
      end
      fork
         run_download();
         dbg_read(11'h03C, 8'h3C, 0, lat);
      join
      wait_run(n);
      fetch(11'h1A5);
      check("fetch_1A5_model", model_mem[11'h1A5], 8'hA5);
      fetch(11'h7FF);

      // Debug steals while the MCU keeps fetching 0x020.
      cpu_addr = 11'h020;
      repeat (3) tick();
      hold_exp = model_mem[11'h020];
      hold_chk = 1'b1;
      dbg_read(11'h010, model_mem[11'h010], 3, lat);
      for (int k = 0; k < 6; k++) begin
         repeat (1 + $urandom_range(0, 2)) tick();
         a = ADDR_W'($urandom_range(0, DEPTH - 1));
         dbg_read(a, model_mem[a], 3, lat);
      end
      repeat (4) tick();
      hold_chk = 1'b0;

      // Out-of-range writes are dropped and flagged.
      w.a = 16'h0800; w.d = 8'h55; wq.push_back(w);
      for (int k = 0; k < 3; k++) begin
         w.a = 16'h0100 + 16'(k);
         w.d = 8'($urandom);
         wq.push_back(w);
      end
      w.a = 16'hFFFF; w.d = 8'($urandom); wq.push_back(w);
      run_download();
      // Debug in SETTLE is granted on the first available cycle.
      dbg_read(11'h101, model_mem[11'h101], 2, lat);
      wait_run(n);
      fetch(11'h000);
      fetch(11'h102);

      // Random short downloads followed by random reads.
      for (int r = 0; r < 3; r++) begin
         int nw = $urandom_range(1, 12);
         for (int k = 0; k < nw; k++) begin
            if ($urandom_range(0, 5) == 0) w.a = 16'($urandom_range(DEPTH, 16'hFFFF));
            else                           w.a = 16'($urandom_range(0, DEPTH - 1));
            w.d = 8'($urandom);
            wq.push_back(w);
         end
         run_download();
         wait_run(n);
         for (int k = 0; k < 3; k++) begin
            a = ADDR_W'($urandom_range(0, DEPTH - 1));
            fetch(a);
            repeat (1 + $urandom_range(0, 1)) tick();
            a = ADDR_W'($urandom_range(0, DEPTH - 1));
            dbg_read(a, model_mem[a], 3, lat);
            tick();
         end
      end

      // Reset in the middle of a download keeps the bytes already written.
      dl_active = 1'b1;
      in_load   = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         dl_wr   = 1'b1;
         dl_addr = 16'h0200 + 16'(k);
         dl_data = 8'($urandom);
         model_mem[ADDR_W'(11'h200 + k)] = dl_data;
         tick();
      end
      dl_wr     = 1'b0;
      dl_active = 1'b0;
      in_load   = 1'b0;
      reset     = 1'b1;
      tick();
      check("mid_rst_byte_cnt", byte_cnt, 0);
      check("mid_rst_loaded", loaded, 0);
      check("mid_rst_dl_ovf", dl_ovf, 0);
      check("mid_rst_cpu_reset", cpu_reset, 1);
      check("mid_rst_cpu_ph", cpu_ph, 0);
      reset   = 1'b0;
      exp_ovf = 1'b0;
      wait_run(n);
      check("reboot_cycles", n, 1 + SETTLE_CYC);
      fetch(11'h202);
      fetch(11'h204);

`ifdef MCU_ROM_CHECKSUM_EN
      // 0x01 + 0x02 + 0xFF = 0x102 -> 0x02 mod 256.
      for (int pass = 0; pass < 2; pass++) begin
         w.a = 16'h0700; w.d = 8'h01; wq.push_back(w);
         w.a = 16'h0701; w.d = 8'h02; wq.push_back(w);
         w.a = 16'h0702; w.d = 8'hFF; wq.push_back(w);
         exp_sum = (pass == 0) ? 8'h02 : 8'h03;
         run_download();
         check("rom_sum", rom_sum, 8'h02);
         check("model_sum", last_sum, rom_sum);
         if (pass == 0) begin
            wait_run(n);
         end else begin
            released = 0;
            repeat (20) begin
               tick();
               if (!cpu_reset) released++;
            end
            check("bad_holds_reset", released, 0);
         end
      end
      w.a = 16'h0703; w.d = 8'h10; wq.push_back(w);
      exp_sum = 8'h10;
      run_download();
      check("rom_sum_recover", rom_sum, 8'h10);
      wait_run(n);
      fetch(11'h702);
`endif

      repeat (4) tick();
      check("dbg_queue_drained", dbg_q.size(), 0);
      check("fetch_queue_drained", fetch_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
